// File: rtl/alu_cmd_initiator.sv
// Initiator between UART RX/TX and the ALU: assembles 5-byte command frames, issues them, returns the group result.
// Build option CARRY_BYTE_EN appends a status byte (carry + captured group one-hot) to every non-error response.
module alu_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYC = 8,
    parameter logic [7:0]  ERR_CODE    = 8'hEE,
    parameter logic [3:0]  SYNC_NIB    = 4'hA
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_READY,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    input  logic [15:0] Arith_OUT,
    input  logic        Carry_OUT,
    input  logic [15:0] Logic_OUT,
    input  logic [15:0] CMP_OUT,
    input  logic [15:0] Shift_OUT,
    input  logic        Arith_Flag,
    input  logic        Logic_Flag,
    input  logic        CMP_Flag,
    input  logic        Shift_Flag,
    output logic        BUSY,
    output logic        FRAME_ERR,
    output logic        RX_OVERRUN,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_A0   = 4'd1,
        GET_A1   = 4'd2,
        GET_B0   = 4'd3,
        GET_B1   = 4'd4,
        ISSUE    = 4'd5,
        WAIT_RES = 4'd6,
        SEND_LO  = 4'd7,
        SEND_HI  = 4'd8,
        SEND_ST  = 4'd9,
        SEND_ERR = 4'd10
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [3:0]  fun_q;
    logic [15:0] a_q;
    logic [7:0]  b_lo_q;
    logic [15:0] res_q;
    logic [7:0]  wait_cnt;

    logic        grp_hit;
    logic [15:0] grp_res;
    logic        tx_accept;
    logic        rx_closed;

    assign state_dbg = state;

    // TX handshake: a byte moves on any clock edge where TX_D_VLD && TX_READY are both high;
    // until then TX_P_DATA and TX_D_VLD are held unchanged by this block.
    assign tx_accept = TX_D_VLD && TX_READY;

    // Bytes are only consumed while assembling a frame; anywhere else they are dropped.
    assign rx_closed = !(state inside {IDLE, GET_A0, GET_A1, GET_B0, GET_B1});

    always_comb begin
        grp_hit = 1'b0;
        grp_res = 16'h0000;
        case (ALU_FUN[3:2])
            2'b00: begin grp_hit = Arith_Flag; grp_res = Arith_OUT; end
            2'b01: begin grp_hit = Logic_Flag; grp_res = Logic_OUT; end
            2'b10: begin grp_hit = CMP_Flag;   grp_res = CMP_OUT;   end
            default: begin grp_hit = Shift_Flag; grp_res = Shift_OUT; end
        endcase
    end

`ifdef CARRY_BYTE_EN
    logic       carry_q;
    logic [7:0] status_byte;
    assign status_byte = {3'b000, carry_q,
                          ALU_FUN[3:2] == 2'b00, ALU_FUN[3:2] == 2'b01,
                          ALU_FUN[3:2] == 2'b10, ALU_FUN[3:2] == 2'b11};
`else
    logic unused_carry;
    assign unused_carry = Carry_OUT;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            fun_q      <= 4'h0;
            a_q        <= 16'h0000;
            b_lo_q     <= 8'h00;
            res_q      <= 16'h0000;
            wait_cnt   <= 8'h00;
            A          <= 16'h0000;
            B          <= 16'h0000;
            ALU_FUN    <= 4'h0;
            ALU_EN     <= 1'b0;
            TX_P_DATA  <= 8'h00;
            TX_D_VLD   <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_ERR  <= 1'b0;
            RX_OVERRUN <= 1'b0;
`ifdef CARRY_BYTE_EN
            carry_q    <= 1'b0;
`endif
        end else begin
            ALU_EN     <= 1'b0;
            FRAME_ERR  <= 1'b0;
            RX_OVERRUN <= RX_D_VLD && rx_closed;

            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA[7:4] == SYNC_NIB) begin
                            fun_q <= RX_P_DATA[3:0];
                            BUSY  <= 1'b1;
                            state <= GET_A0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                end
                GET_A0: begin
                    if (RX_D_VLD) begin
                        a_q[7:0] <= RX_P_DATA;
                        state    <= GET_A1;
                    end
                end
                GET_A1: begin
                    if (RX_D_VLD) begin
                        a_q[15:8] <= RX_P_DATA;
                        state     <= GET_B0;
                    end
                end
                GET_B0: begin
                    if (RX_D_VLD) begin
                        b_lo_q <= RX_P_DATA;
                        state  <= GET_B1;
                    end
                end
                GET_B1: begin
                    // Operands go out together so they are already stable during the issue cycle.
                    if (RX_D_VLD) begin
                        A       <= a_q;
                        B       <= {RX_P_DATA, b_lo_q};
                        ALU_FUN <= fun_q;
                        ALU_EN  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 8'h00;
                    state    <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (grp_hit) begin
                        res_q     <= grp_res;
                        TX_P_DATA <= grp_res[7:0];
                        TX_D_VLD  <= 1'b1;
                        state     <= SEND_LO;
`ifdef CARRY_BYTE_EN
                        carry_q   <= (ALU_FUN[3:2] == 2'b00) ? Carry_OUT : 1'b0;
`endif
                    end else if (wait_cnt == WAIT_LAST) begin
                        TX_P_DATA <= ERR_CODE;
                        TX_D_VLD  <= 1'b1;
                        state     <= SEND_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                SEND_LO: begin
                    if (tx_accept) begin
                        TX_P_DATA <= res_q[15:8];
                        state     <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (tx_accept) begin
`ifdef CARRY_BYTE_EN
                        TX_P_DATA <= status_byte;
                        state     <= SEND_ST;
`else
                        TX_D_VLD  <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
`endif
                    end
                end
`ifdef CARRY_BYTE_EN
                SEND_ST: begin
                    if (tx_accept) begin
                        TX_D_VLD <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                SEND_ERR: begin
                    if (tx_accept) begin
                        TX_D_VLD <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    TX_D_VLD <= 1'b0;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed bench for alu_cmd_initiator: frame driver, cycle-based ALU model, TX sink and byte scoreboard.
module tb_alu_cmd_initiator;

    localparam int TMO = 8;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_READY;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] arith_out;
    logic [15:0] logic_out;
    logic [15:0] cmp_out;
    logic [15:0] shift_out;
    logic        carry_out;
    logic [3:0]  flags;
    logic        BUSY;
    logic        FRAME_ERR;
    logic        RX_OVERRUN;
    logic [3:0]  state_dbg;

    alu_cmd_initiator #(.TIMEOUT_CYC(TMO), .ERR_CODE(8'hEE), .SYNC_NIB(4'hA)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .Arith_OUT(arith_out), .Carry_OUT(carry_out), .Logic_OUT(logic_out),
        .CMP_OUT(cmp_out), .Shift_OUT(shift_out),
        .Arith_Flag(flags[0]), .Logic_Flag(flags[1]), .CMP_Flag(flags[2]), .Shift_Flag(flags[3]),
        .BUSY(BUSY), .FRAME_ERR(FRAME_ERR), .RX_OVERRUN(RX_OVERRUN), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int cyc = 0;
    int en_cyc = 0;
    int vld_rise_cyc = 0;
    int en_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int wait_n = 0;
    bit en_seen = 0;
    bit vld_prev = 0;

    int mdl_grp = -1;
    int mdl_dly = 1;
    bit mdl_toggle = 0;

    // ALU model and monitors: everything sampled on the falling edge, flags change there too.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        flags = 4'b0000;
        if (ALU_EN) begin
            en_seen = 1;
            wait_n  = 0;
            en_cnt  = en_cnt + 1;
            en_cyc  = cyc;
        end else if (en_seen) begin
            wait_n = wait_n + 1;
            if (mdl_toggle) flags[1] = wait_n[0];
            if (mdl_grp >= 0 && wait_n == mdl_dly) begin
                flags[mdl_grp] = 1'b1;
                en_seen = 0;
            end
            if (wait_n > 40) en_seen = 0;
        end
        if (TX_D_VLD && TX_READY) got_q.push_back(TX_P_DATA);
        if (TX_D_VLD && !vld_prev) vld_rise_cyc = cyc;
        vld_prev = TX_D_VLD;
        if (FRAME_ERR) fe_cnt = fe_cnt + 1;
        if (RX_OVERRUN) ov_cnt = ov_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] status_of(input logic carry, input int grp);
        status_of = {3'b000, carry, grp == 0, grp == 1, grp == 2, grp == 3};
    endfunction

    task automatic expect_resp(input logic [15:0] res, input logic carry, input int grp);
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
`ifdef CARRY_BYTE_EN
        exp_q.push_back(status_of(carry, grp));
`else
        if (carry && grp < 0) exp_q.push_back(8'h00);
`endif
    endtask

    task automatic check_resp(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check($sformatf("%s_byte%0d", tag, i), g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- drivers (enter and leave at posedge + 1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        send_byte(op);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < 200) begin
            tick(1);
            n = n + 1;
        end
        check({tag, "_idle"}, BUSY, 1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int  en0;
    int  fe0;
    int  ov0;
    bit  stable;
    int  n;

    initial begin
        RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; TX_READY = 1'b1;
        arith_out = 16'h0; logic_out = 16'h0; cmp_out = 16'h0; shift_out = 16'h0;
        carry_out = 1'b0; flags = 4'b0;
        tick(3);
        RST = 1'b0;

        check("rst_A", A, 16'h0);
        check("rst_B", B, 16'h0);
        check("rst_fun", ALU_FUN, 4'h0);
        check("rst_en", ALU_EN, 1'b0);
        check("rst_txd", TX_P_DATA, 8'h00);
        check("rst_txv", TX_D_VLD, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_ferr", FRAME_ERR, 1'b0);
        check("rst_ovr", RX_OVERRUN, 1'b0);
        check("rst_state", state_dbg, 4'd0);

        // Arithmetic: 10 + 5 = 15, flag one cycle after ALU_EN
        mdl_grp = 0; mdl_dly = 1; arith_out = 16'd15; carry_out = 1'b0;
        en0 = en_cnt;
        send_frame(8'hA0, 16'h000A, 16'h0005);
        wait_idle("add");
        check("add_A", A, 16'h000A);
        check("add_B", B, 16'h0005);
        check("add_fun", ALU_FUN, 4'h0);
        check("add_en_pulses", en_cnt - en0, 1);
        check("add_latency", vld_rise_cyc - en_cyc, 2);
        expect_resp(16'h000F, 1'b0, 0);
        check_resp("add");
        check("add_txv_low", TX_D_VLD, 1'b0);

        // Compare group, flag 3 cycles late, logic flag toggling meanwhile
        mdl_grp = 2; mdl_dly = 3; mdl_toggle = 1; cmp_out = 16'h0000; logic_out = 16'h1234;
        send_frame(8'hAA, 16'd10, 16'd117);
        wait_idle("cmp");
        mdl_toggle = 0;
        check("cmp_A", A, 16'd10);
        check("cmp_B", B, 16'd117);
        check("cmp_fun", ALU_FUN, 4'hA);
        check("cmp_latency", vld_rise_cyc - en_cyc, 4);
        expect_resp(16'h0000, 1'b0, 2);
        check_resp("cmp");

        // Bad sync nibble, then a logic-group frame
        fe0 = fe_cnt;
        en0 = en_cnt;
        send_byte(8'h30);
        tick(4);
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_busy", BUSY, 1'b0);
        check("ferr_no_tx", got_q.size(), 0);
        check("ferr_no_en", en_cnt - en0, 0);
        mdl_grp = 1; mdl_dly = 2; logic_out = 16'h0204;
        send_frame(8'hA5, 16'h1234, 16'h000F);
        wait_idle("log");
        check("log_A", A, 16'h1234);
        check("log_B", B, 16'h000F);
        check("log_fun", ALU_FUN, 4'h5);
        expect_resp(16'h0204, 1'b0, 1);
        check_resp("log");

        // Timeout: no flags at all on a shift-group frame
        mdl_grp = -1;
        send_frame(8'hAC, 16'h0001, 16'h0002);
        wait_idle("tmo");
        check("tmo_latency", vld_rise_cyc - en_cyc, TMO + 1);
        exp_q.push_back(8'hEE);
        check_resp("tmo");

        // Backpressure in SEND_LO with an RX byte injected
        mdl_grp = 0; mdl_dly = 1; arith_out = 16'hBEEF; carry_out = 1'b0;
        TX_READY = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'hA1, 16'h0003, 16'h0004);
        n = 0;
        while (TX_D_VLD !== 1'b1 && n < 50) begin
            tick(1);
            n = n + 1;
        end
        check("bp_vld_seen", TX_D_VLD, 1'b1);
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            if (TX_P_DATA !== 8'hEF || TX_D_VLD !== 1'b1) stable = 0;
            RX_P_DATA = 8'hA0;
            RX_D_VLD  = (i == 1);
            tick(1);
        end
        RX_D_VLD = 1'b0;
        check("bp_stable", stable, 1'b1);
        check("bp_busy", BUSY, 1'b1);
        check("bp_overrun", ov_cnt - ov0, 1);
        TX_READY = 1'b1;
        wait_idle("bp");
        expect_resp(16'hBEEF, 1'b0, 0);
        check_resp("bp");

        // Reset mid-frame, then a carry-producing frame
        send_byte(8'hA0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("mid_busy", BUSY, 1'b1);
        do_reset();
        check("mid_rst_A", A, 16'h0);
        check("mid_rst_B", B, 16'h0);
        check("mid_rst_fun", ALU_FUN, 4'h1 & 4'h0);
        check("mid_rst_busy", BUSY, 1'b0);
        mdl_grp = 0; mdl_dly = 1; arith_out = 16'h0000; carry_out = 1'b1;
        send_frame(8'hA0, 16'h8000, 16'h8000);
        wait_idle("cy");
        check("cy_A", A, 16'h8000);
        check("cy_B", B, 16'h8000);
        expect_resp(16'h0000, 1'b1, 0);
        check_resp("cy");
        check("cy_ovr_none", ov_cnt - ov0, 1);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
